// File: rtl/regfile_arb_pkg.sv
// Shared widths, default queue depth and writeback port indices for the
// register-file write arbiter.
package regfile_arb_pkg;

  localparam int REG_AW        = 5;
  localparam int DATA_W        = 32;
  localparam int DEFAULT_DEPTH = 2;

  typedef enum logic {
    PORT_ALU  = 1'b0,
    PORT_LOAD = 1'b1
  } port_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular writeback queue; exposes per-slot valid/register so the
// arbiter can detect pending writes without popping.
module wb_fifo
  import regfile_arb_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  output logic [CW-1:0]                 count,
  output wb_entry_t                     head,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  ent_reg
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    // Clear the popped slot before filling so a push into the same slot wins.
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      mem_d[wr_ptr_q]   = push_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    ent_reg = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_reg[i] = mem_q[i].rd;
    end
  end

  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign ent_valid = valid_q;

endmodule

// File: rtl/regfile_write_arb.sv
// Two-port register-file writeback arbiter: per-port queues, round-robin
// grant into a single registered write port, and pending-write hazard flags.
module regfile_write_arb
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int NPORT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [REG_AW-1:0] p0_reg,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [REG_AW-1:0] p1_reg,
  input  logic [DATA_W-1:0] p1_data,
  output logic              RegWrite,
  output logic [REG_AW-1:0] Writeregister,
  output logic [DATA_W-1:0] Writedata,
  input  logic [REG_AW-1:0] readregister1,
  input  logic [REG_AW-1:0] readregister2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              idle
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t [NPORT-1:0]                   push_entry;
  wb_entry_t [NPORT-1:0]                   head;
  logic [NPORT-1:0]                        in_valid;
  logic [NPORT-1:0]                        ready;
  logic [NPORT-1:0]                        push;
  logic [NPORT-1:0]                        non_empty;
  logic [NPORT-1:0]                        grant;
  logic [NPORT-1:0][CW-1:0]                count;
  logic [NPORT-1:0][DEPTH-1:0]             ent_valid;
  logic [NPORT-1:0][DEPTH-1:0][REG_AW-1:0] ent_reg;

  port_e             rr_q, rr_d;
  logic              reg_write_q, reg_write_d;
  logic [REG_AW-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  assign in_valid[PORT_ALU]   = p0_valid;
  assign in_valid[PORT_LOAD]  = p1_valid;
  assign push_entry[PORT_ALU]  = '{rd: p0_reg, data: p0_data};
  assign push_entry[PORT_LOAD] = '{rd: p1_reg, data: p1_data};
  assign p0_ready = ready[PORT_ALU];
  assign p1_ready = ready[PORT_LOAD];

  // Writes to $zero are handshaken normally but never enter a queue.
  for (genvar g = 0; g < NPORT; g++) begin : g_port
    assign ready[g]     = count[g] < CW'(DEPTH);
    assign push[g]      = in_valid[g] && ready[g] && (push_entry[g].rd != '0);
    assign non_empty[g] = count[g] != '0;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push[g]),
      .push_entry (push_entry[g]),
      .pop        (grant[g]),
      .count      (count[g]),
      .head       (head[g]),
      .ent_valid  (ent_valid[g]),
      .ent_reg    (ent_reg[g])
    );
  end

  // The pointer only moves on contention, handing priority to the loser.
  always_comb begin
    grant = '0;
    rr_d  = rr_q;
    if (non_empty[PORT_ALU] && non_empty[PORT_LOAD]) begin
      grant[rr_q] = 1'b1;
      rr_d        = (rr_q == PORT_ALU) ? PORT_LOAD : PORT_ALU;
    end else begin
      grant = non_empty;
    end
  end

  always_comb begin
    reg_write_d = |grant;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (grant[PORT_ALU]) begin
      wr_reg_d  = head[PORT_ALU].rd;
      wr_data_d = head[PORT_ALU].data;
    end else if (grant[PORT_LOAD]) begin
      wr_reg_d  = head[PORT_LOAD].rd;
      wr_data_d = head[PORT_LOAD].data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q        <= PORT_ALU;
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // A register stays hazardous until its write has left the output stage.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[p][i] && (ent_reg[p][i] == readregister1)) hazard1 = 1'b1;
        if (ent_valid[p][i] && (ent_reg[p][i] == readregister2)) hazard2 = 1'b1;
      end
    end
    if (reg_write_q && (wr_reg_q == readregister1)) hazard1 = 1'b1;
    if (reg_write_q && (wr_reg_q == readregister2)) hazard2 = 1'b1;
    if (readregister1 == '0) hazard1 = 1'b0;
    if (readregister2 == '0) hazard2 = 1'b0;
  end

  assign RegWrite      = reg_write_q;
  assign Writeregister = wr_reg_q;
  assign Writedata     = wr_data_q;
  assign idle          = !(|non_empty) && !reg_write_q;

endmodule

// File: tb/tb_regfile_write_arb.sv
// Directed bench for regfile_write_arb; expected writes are queued in
// hand-computed order and popped by a monitor on every RegWrite cycle.
module tb_regfile_write_arb;

  logic        clk;
  logic        reset;
  logic        p0_valid, p1_valid;
  logic        p0_ready, p1_ready;
  logic [4:0]  p0_reg, p1_reg;
  logic [31:0] p0_data, p1_data;
  logic        RegWrite;
  logic [4:0]  Writeregister;
  logic [31:0] Writedata;
  logic [4:0]  readregister1, readregister2;
  logic        hazard1, hazard2, idle;

  int          test_count = 0;
  int          fail_count = 0;
  logic [36:0] exp_q[$];
  logic [36:0] exp_entry;

  regfile_write_arb #(.DEPTH(2), .NPORT(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .p0_valid      (p0_valid),
    .p0_ready      (p0_ready),
    .p0_reg        (p0_reg),
    .p0_data       (p0_data),
    .p1_valid      (p1_valid),
    .p1_ready      (p1_ready),
    .p1_reg        (p1_reg),
    .p1_data       (p1_data),
    .RegWrite      (RegWrite),
    .Writeregister (Writeregister),
    .Writedata     (Writedata),
    .readregister1 (readregister1),
    .readregister2 (readregister2),
    .hazard1       (hazard1),
    .hazard2       (hazard2),
    .idle          (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    p0_valid = v0; p0_reg = r0; p0_data = d0;
    p1_valid = v1; p1_reg = r1; p1_data = d1;
  endtask

  // Present inputs across exactly one rising edge, returning 1ns after it.
  task automatic applyStimulus(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    drive(v0, r0, d0, v1, r1, d1);
    @(posedge clk);
    #1;
  endtask

  task automatic expectWrite(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  always @(negedge clk) begin
    if (!reset && RegWrite) begin
      if (exp_q.size() == 0) begin
        test_count++;
        fail_count++;
        $display("[TB] FAIL unexpected_write: got reg %0d data 0x%0h, expected no write",
                 Writeregister, Writedata);
      end else begin
        exp_entry = exp_q.pop_front();
        checkOutput("write_stream", {27'd0, Writeregister, Writedata}, {27'd0, exp_entry});
      end
    end
  end

  initial begin
    #100000;
    fail_count++;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000ns");
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

  initial begin
    reset = 1'b1;
    readregister1 = 5'd5;
    readregister2 = 5'd0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_regwrite", RegWrite, 0);
    checkOutput("reset_wreg", Writeregister, 0);
    checkOutput("reset_wdata", Writedata, 0);
    checkOutput("reset_ready0", p0_ready, 1);
    checkOutput("reset_ready1", p1_ready, 1);
    checkOutput("reset_idle", idle, 1);
    checkOutput("reset_hazard1", hazard1, 0);
    reset = 1'b0;

    // Single write, minimum latency.
    expectWrite(5'd5, 32'h1234_5678);
    applyStimulus(1, 5'd5, 32'h1234_5678, 0, 0, 0);
    checkOutput("lat_regwrite_early", RegWrite, 0);
    checkOutput("lat_idle_busy", idle, 0);
    checkOutput("lat_hazard_queued", hazard1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lat_regwrite", RegWrite, 1);
    checkOutput("lat_wreg", Writeregister, 5);
    checkOutput("lat_wdata", Writedata, 32'h1234_5678);
    checkOutput("lat_idle_out", idle, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lat_regwrite_done", RegWrite, 0);
    checkOutput("lat_idle_back", idle, 1);
    checkOutput("lat_wreg_hold", Writeregister, 5);
    checkOutput("lat_hazard_clear", hazard1, 0);

    // Both ports contending: alternate starting from port 0.
    expectWrite(5'd1, 32'h11); expectWrite(5'd3, 32'h33);
    expectWrite(5'd2, 32'h22); expectWrite(5'd4, 32'h44);
    applyStimulus(1, 5'd1, 32'h11, 1, 5'd3, 32'h33);
    applyStimulus(1, 5'd2, 32'h22, 1, 5'd4, 32'h44);
    checkOutput("rr_first", Writeregister, 1);
    checkOutput("rr_p1_full", p1_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rr_second", Writeregister, 3);
    checkOutput("rr_second_we", RegWrite, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rr_third", Writeregister, 2);
    checkOutput("rr_third_we", RegWrite, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rr_fourth", Writeregister, 4);
    checkOutput("rr_fourth_we", RegWrite, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rr_drained", idle, 1);

    // Write to $zero is accepted and dropped.
    checkOutput("zero_ready", p1_ready, 1);
    applyStimulus(0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF);
    checkOutput("zero_idle", idle, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("zero_no_write", RegWrite, 0);
      checkOutput("zero_idle_hold", idle, 1);
    end

    // Port 0 backpressure: port 1 wins once so port 0 fills to DEPTH.
    expectWrite(5'd9, 32'h99);  expectWrite(5'd8, 32'h88);
    expectWrite(5'd10, 32'hAA); expectWrite(5'd11, 32'hBB);
    applyStimulus(1, 5'd8, 32'h88, 1, 5'd9, 32'h99);
    applyStimulus(1, 5'd10, 32'hAA, 0, 0, 0);
    checkOutput("full_ready_low", p0_ready, 0);
    checkOutput("full_out_p1", Writeregister, 9);
    applyStimulus(1, 5'd11, 32'hBB, 0, 0, 0);
    checkOutput("full_ready_back", p0_ready, 1);
    checkOutput("full_out_a", Writeregister, 8);
    applyStimulus(1, 5'd11, 32'hBB, 0, 0, 0);
    checkOutput("full_pushpop_ready", p0_ready, 1);
    checkOutput("full_out_b", Writeregister, 10);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("full_out_c", Writeregister, 11);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("full_idle", idle, 1);

    // Hazard tracking through queue and output stage.
    readregister1 = 5'd7;
    readregister2 = 5'd0;
    expectWrite(5'd7, 32'h77);
    #1;
    checkOutput("haz_none_yet", hazard1, 0);
    applyStimulus(1, 5'd7, 32'h77, 0, 0, 0);
    checkOutput("haz_queued", hazard1, 1);
    checkOutput("haz2_zero_q", hazard2, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("haz_output", hazard1, 1);
    checkOutput("haz_output_we", RegWrite, 1);
    checkOutput("haz2_zero_o", hazard2, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("haz_cleared", hazard1, 0);
    checkOutput("haz2_zero_end", hazard2, 0);

    // Reset mid-stream with both queues occupied.
    expectWrite(5'd12, 32'hC);
    applyStimulus(1, 5'd12, 32'hC, 1, 5'd13, 32'hD);
    applyStimulus(1, 5'd14, 32'hE, 1, 5'd15, 32'hF);
    drive(0, 0, 0, 0, 0, 0);
    readregister1 = 5'd14;
    readregister2 = 5'd15;
    #1;
    checkOutput("mid_regwrite", RegWrite, 1);
    checkOutput("mid_hazard1", hazard1, 1);
    checkOutput("mid_hazard2", hazard2, 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("arst_regwrite", RegWrite, 0);
    checkOutput("arst_wreg", Writeregister, 0);
    checkOutput("arst_wdata", Writedata, 0);
    checkOutput("arst_idle", idle, 1);
    checkOutput("arst_ready0", p0_ready, 1);
    checkOutput("arst_ready1", p1_ready, 1);
    checkOutput("arst_hazard1", hazard1, 0);
    checkOutput("arst_hazard2", hazard2, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_no_write", RegWrite, 0);
    checkOutput("post_rst_idle", idle, 1);

    // Pointer back at port 0: port 0 wins the first contended grant.
    expectWrite(5'd20, 32'h20); expectWrite(5'd21, 32'h21);
    applyStimulus(1, 5'd20, 32'h20, 1, 5'd21, 32'h21);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_rr_first", Writeregister, 20);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_rr_second", Writeregister, 21);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_idle_end", idle, 1);

    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
